nvdla_csb_master: RTL and testbench

- Initiator side of the NVDLA CSB register bus.
- Accepts single register requests (read, posted write, non-posted write) from the HWPE control slave and drives the csb2nvdla valid/ready channel.
- Collects the nvdla2csb read data or write-complete, then returns one response per request on a valid/ready channel.
- Replaces the single-flop valid pulse in the engine with a full one-outstanding transaction FSM that has a timeout.

---
 rtl/nvdla_package.sv | 27 ++
 rtl/nvdla_csb_master.sv | 171 +++++++++++++++++
 tb/tb_nvdla_csb_master.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nvdla_package.sv
// Shared CSB types for the NVDLA integration: bus widths, request and
// response bundles, and the master FSM state encoding.
package nvdla_package;

  localparam int CSB_ADDR_W = 16;
  localparam int CSB_DATA_W = 32;

  typedef struct packed {
    logic [CSB_ADDR_W-1:0] addr;
    logic [CSB_DATA_W-1:0] wdat;
    logic                  write;
    logic                  nposted;
  } csb_req_t;

  typedef struct packed {
    logic [CSB_DATA_W-1:0] rdata;
    logic                  error;
  } csb_rsp_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } csb_master_state_t;

endpackage

// File: rtl/nvdla_csb_master.sv
// CSB initiator: one outstanding register transaction at a time, with a
// bounded wait for read data / write completion and a sticky flag for
// responses nobody asked for.
module nvdla_csb_master
  import nvdla_package::*;
#(
  parameter int ADDR_W         = CSB_ADDR_W,
  parameter int DATA_W         = CSB_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdat_i,
  input  logic              req_write_i,
  input  logic              req_nposted_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_error_o,
  output logic              csb_valid_o,
  input  logic              csb_ready_i,
  output logic [ADDR_W-1:0] csb_addr_o,
  output logic [DATA_W-1:0] csb_wdat_o,
  output logic              csb_write_o,
  output logic              csb_nposted_o,
  input  logic              csb_rvalid_i,
  input  logic [DATA_W-1:0] csb_rdata_i,
  input  logic              csb_wr_complete_i,
  output logic              busy_o,
  output logic              stray_o
);

  localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  csb_master_state_t state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [DATA_W-1:0] wdat, wdat_nxt;
  logic              write, write_nxt;
  logic              nposted, nposted_nxt;   // already qualified with write
  logic [DATA_W-1:0] rdata, rdata_nxt;
  logic              error, error_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              stray, stray_nxt;
  logic              want_rd, want_wc, rd_hit, wc_hit, mismatch;

  // Which response type the captured transaction is waiting for.
  always_comb begin
    want_rd  = !write;
    want_wc  = nposted;
    rd_hit   = want_rd && csb_rvalid_i;
    wc_hit   = want_wc && csb_wr_complete_i;
    mismatch = (csb_rvalid_i && !want_rd) || (csb_wr_complete_i && !want_wc);
  end

  // Next-state, capture and stray detection; clear overrides everything last.
  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr;
    wdat_nxt    = wdat;
    write_nxt   = write;
    nposted_nxt = nposted;
    rdata_nxt   = rdata;
    error_nxt   = error;
    cnt_nxt     = cnt;
    stray_nxt   = stray;
    case (state)
      IDLE: begin
        if (csb_rvalid_i || csb_wr_complete_i) stray_nxt = 1'b1;
        if (req_valid_i) begin
          addr_nxt    = req_addr_i;
          wdat_nxt    = req_wdat_i;
          write_nxt   = req_write_i;
          nposted_nxt = req_write_i && req_nposted_i;
          rdata_nxt   = '0;
          error_nxt   = 1'b0;
          state_nxt   = REQ;
        end
      end
      REQ: begin
        if (csb_ready_i) begin
          if (mismatch) stray_nxt = 1'b1;
          if (write && !nposted) begin
            state_nxt = RESP;
          end else if (rd_hit) begin
            rdata_nxt = csb_rdata_i;
            state_nxt = RESP;
          end else if (wc_hit) begin
            state_nxt = RESP;
          end else begin
            cnt_nxt   = '0;
            state_nxt = WAIT;
          end
        end else if (csb_rvalid_i || csb_wr_complete_i) begin
          stray_nxt = 1'b1;
        end
      end
      WAIT: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (mismatch) stray_nxt = 1'b1;
        if (rd_hit) begin
          rdata_nxt = csb_rdata_i;
          state_nxt = RESP;
        end else if (wc_hit) begin
          state_nxt = RESP;
        end else if (cnt == CNT_LAST) begin
          error_nxt = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (csb_rvalid_i || csb_wr_complete_i) stray_nxt = 1'b1;
        if (rsp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clear_i) begin
      state_nxt   = IDLE;
      addr_nxt    = '0;
      wdat_nxt    = '0;
      write_nxt   = 1'b0;
      nposted_nxt = 1'b0;
      rdata_nxt   = '0;
      error_nxt   = 1'b0;
      cnt_nxt     = '0;
      stray_nxt   = 1'b0;
    end
  end

  // State and captured transaction registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      addr    <= '0;
      wdat    <= '0;
      write   <= 1'b0;
      nposted <= 1'b0;
      rdata   <= '0;
      error   <= 1'b0;
      cnt     <= '0;
      stray   <= 1'b0;
    end else begin
      state   <= state_nxt;
      addr    <= addr_nxt;
      wdat    <= wdat_nxt;
      write   <= write_nxt;
      nposted <= nposted_nxt;
      rdata   <= rdata_nxt;
      error   <= error_nxt;
      cnt     <= cnt_nxt;
      stray   <= stray_nxt;
    end
  end

  assign req_ready_o   = (state == IDLE) && !rst_i && !clear_i;
  assign csb_valid_o   = (state == REQ);
  assign csb_addr_o    = addr;
  assign csb_wdat_o    = wdat;
  assign csb_write_o   = write;
  assign csb_nposted_o = nposted;
  assign rsp_valid_o   = (state == RESP);
  assign rsp_rdata_o   = rdata;
  assign rsp_error_o   = error;
  assign busy_o        = (state != IDLE);
  assign stray_o       = stray;

endmodule

// File: tb/tb_nvdla_csb_master.sv
// Bench for the CSB initiator: directed cases followed by randomized
// transactions, each judged by a transaction-level reference model.
module tb_nvdla_csb_master;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst, clear;
  logic        req_valid, req_ready, req_write, req_nposted;
  logic [15:0] req_addr;
  logic [31:0] req_wdat;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;
  logic        csb_valid, csb_ready, csb_write, csb_nposted;
  logic [15:0] csb_addr;
  logic [31:0] csb_wdat;
  logic        csb_rvalid, csb_wr_complete;
  logic [31:0] csb_rdata;
  logic        busy, stray;

  always #5 clk = ~clk;

  nvdla_csb_master #(.ADDR_W(16), .DATA_W(32), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_wdat_i(req_wdat), .req_write_i(req_write), .req_nposted_i(req_nposted),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_error_o(rsp_error),
    .csb_valid_o(csb_valid), .csb_ready_i(csb_ready), .csb_addr_o(csb_addr),
    .csb_wdat_o(csb_wdat), .csb_write_o(csb_write), .csb_nposted_o(csb_nposted),
    .csb_rvalid_i(csb_rvalid), .csb_rdata_i(csb_rdata),
    .csb_wr_complete_i(csb_wr_complete),
    .busy_o(busy), .stray_o(stray)
  );

  // k: cycles from the csb handshake to the response (0 = same cycle);
  // k > T means no response in time. late: response shows up in RESP.
  typedef struct {
    bit          write;
    bit          nposted;
    logic [15:0] addr;
    logic [31:0] wdat;
    logic [31:0] rdata;
    int          rdy;
    int          k;
    int          rresp;
    bit          late;
    bit          spur;
  } txn_t;

  int n_checks = 0;
  int n_pass   = 0;
  bit stray_exp = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic txn_t mk(input bit w, input bit np, input logic [15:0] a,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input int rdy, input int k, input int rresp,
                              input bit late, input bit spur);
    txn_t t;
    t.write = w; t.nposted = np; t.addr = a; t.wdat = wd; t.rdata = rd;
    t.rdy = rdy; t.k = k; t.rresp = rresp; t.late = late; t.spur = spur;
    return t;
  endfunction

  task automatic drop_nvdla();
    csb_ready = 1'b0; csb_rvalid = 1'b0; csb_wr_complete = 1'b0; csb_rdata = $urandom;
  endtask

  task automatic present(input txn_t t);
    req_valid = 1'b1; req_addr = t.addr; req_wdat = t.wdat;
    req_write = t.write; req_nposted = t.nposted;
  endtask

  task automatic run_txn(input txn_t t, input txn_t nxt, input bit hold, input bit pre);
    bit          npw, waits, exp_err;
    int          last;
    logic [31:0] exp_rdata;
    npw   = t.write && t.nposted;
    waits = !t.write || npw;
    if (!pre) begin
      present(t);
      @(negedge clk);
      check("accept_ready", req_ready, 1);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; req_addr = $urandom; req_wdat = $urandom;
    req_write = $urandom; req_nposted = $urandom;
    // request phase: fields must come from the captured request
    for (int i = 0; i <= t.rdy; i++) begin
      csb_ready = (i == t.rdy);
      if (i == t.rdy && t.k == 0 && waits) begin
        if (t.write) csb_wr_complete = 1'b1;
        else begin csb_rvalid = 1'b1; csb_rdata = t.rdata; end
      end else if (i < t.rdy && $urandom_range(0, 7) == 0) begin
        csb_rvalid = 1'b1; stray_exp = 1'b1;
      end
      @(negedge clk);
      check("csb_valid", csb_valid, 1);
      check("csb_addr", csb_addr, t.addr);
      check("csb_wdat", csb_wdat, t.wdat);
      check("csb_write", csb_write, t.write);
      check("csb_nposted", csb_nposted, npw);
      check("req_ready_busy", req_ready, 0);
      @(posedge clk); #1; drop_nvdla();
    end
    // waiting phase: response wins at k <= T, otherwise timeout after T cycles
    if (waits && t.k > 0) begin
      last = (t.k <= T) ? t.k : T;
      for (int j = 1; j <= last; j++) begin
        if (j == t.k) begin
          if (t.write) csb_wr_complete = 1'b1;
          else begin csb_rvalid = 1'b1; csb_rdata = t.rdata; end
        end else if ((t.spur && j == 1) || $urandom_range(0, 5) == 0) begin
          if (t.write) csb_rvalid = 1'b1; else csb_wr_complete = 1'b1;
          stray_exp = 1'b1;
        end
        @(negedge clk);
        check("wait_busy", busy, 1);
        check("wait_csb_valid", csb_valid, 0);
        check("wait_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1; drop_nvdla();
      end
    end
    // response phase
    exp_rdata = (!t.write && t.k <= T) ? t.rdata : 32'h0;
    exp_err   = waits && (t.k > T);
    if (hold) present(nxt);
    for (int r = 0; r <= t.rresp; r++) begin
      rsp_ready = (r == t.rresp);
      if (r == 0 && t.late) begin
        if (t.write) csb_wr_complete = 1'b1; else csb_rvalid = 1'b1;
        stray_exp = 1'b1;
      end
      @(negedge clk);
      check("rsp_valid", rsp_valid, 1);
      check("rsp_rdata", rsp_rdata, exp_rdata);
      check("rsp_error", rsp_error, exp_err);
      check("req_ready_resp", req_ready, 0);
      check("resp_csb_valid", csb_valid, 0);
      @(posedge clk); #1; rsp_ready = 1'b0; drop_nvdla();
    end
    @(negedge clk);
    check("stray", stray, stray_exp);
    check("idle_busy", busy, 0);
    check("idle_rsp_valid", rsp_valid, 0);
    check("idle_req_ready", req_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    check("clear_req_ready", req_ready, 0);
    @(posedge clk); #1;
    clear = 1'b0; stray_exp = 1'b0;
    @(negedge clk);
    check("clear_stray", stray, 0);
    check("clear_busy", busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    txn_t tq[$];
    bit   hq[$];
    txn_t t;
    bit   pre, w;
    int   k;

    rst = 1'b1; clear = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdat = '0;
    req_write = 1'b0; req_nposted = 1'b0; rsp_ready = 1'b0;
    csb_ready = 1'b0; csb_rvalid = 1'b0; csb_wr_complete = 1'b0; csb_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_csb_valid", csb_valid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_error", rsp_error, 0);
    check("rst_stray", stray, 0);
    check("rst_csb_addr", csb_addr, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // directed: read, posted write with stall, non-posted write with spurious
    // rvalid, timeout plus late rvalid, response on the timeout cycle,
    // zero-wait read, and response backpressure with the next request held.
    tq.push_back(mk(0, 0, 16'h0004, 32'h0, 32'h1234_5678, 0, 2, 0, 0, 0));     hq.push_back(0);
    tq.push_back(mk(1, 0, 16'h0010, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 5, 0, 0, 0, 0)); hq.push_back(0);
    tq.push_back(mk(1, 1, 16'h0020, 32'h0BAD_F00D, 32'h0, 0, 2, 0, 0, 1));     hq.push_back(0);
    tq.push_back(mk(0, 0, 16'h0030, 32'h0, 32'h5555_AAAA, 0, T + 1, 0, 1, 0)); hq.push_back(0);
    tq.push_back(mk(0, 0, 16'h0034, 32'h0, 32'hCAFE_0001, 1, T, 0, 0, 0));     hq.push_back(0);
    tq.push_back(mk(0, 0, 16'h0038, 32'h0, 32'h0F0F_0F0F, 0, 0, 0, 0, 0));     hq.push_back(0);
    tq.push_back(mk(0, 0, 16'h0040, 32'h0, 32'h1111_2222, 0, 1, 4, 0, 0));     hq.push_back(1);
    tq.push_back(mk(1, 0, 16'h0044, 32'h3333_4444, 32'h0, 0, 0, 0, 0, 0));     hq.push_back(0);
    for (int i = 0; i < 32; i++) begin
      w = $urandom_range(0, 1);
      k = $urandom_range(0, T + 2);
      t = mk(w, $urandom_range(0, 1), $urandom, $urandom, $urandom,
             $urandom_range(0, 3), k, $urandom_range(0, 2),
             (k > T) && ($urandom_range(0, 1) == 1), 0);
      tq.push_back(t);
      hq.push_back($urandom_range(0, 1));
    end

    pre = 1'b0;
    foreach (tq[i]) begin
      if (!pre && i > 0 && (i % 8) == 0) do_clear();
      run_txn(tq[i], tq[(i + 1 < tq.size()) ? i + 1 : i],
              hq[i] && (i + 1 < tq.size()), pre);
      pre = hq[i] && (i + 1 < tq.size());
    end

    // clear while waiting for read data
    req_valid = 1'b1; req_addr = 16'h0050; req_write = 1'b0; req_nposted = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0; csb_ready = 1'b1;
    @(negedge clk);
    check("cw_csb_valid", csb_valid, 1);
    @(posedge clk); #1; drop_nvdla();
    csb_wr_complete = 1'b1;
    @(negedge clk);
    check("cw_wait_busy", busy, 1);
    @(posedge clk); #1; drop_nvdla();
    clear = 1'b1;
    @(negedge clk);
    check("cw_stray_set", stray, 1);
    @(posedge clk); #1;
    clear = 1'b0; stray_exp = 1'b0;
    @(negedge clk);
    check("cw_busy", busy, 0);
    check("cw_csb_valid_low", csb_valid, 0);
    check("cw_rsp_valid", rsp_valid, 0);
    check("cw_rsp_error", rsp_error, 0);
    check("cw_rsp_rdata", rsp_rdata, 0);
    check("cw_stray", stray, 0);
    check("cw_csb_addr", csb_addr, 0);
    check("cw_req_ready", req_ready, 1);

    // asynchronous reset while the request is stalled
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 16'h0060;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rr_csb_valid", csb_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("rr_csb_valid_low", csb_valid, 0);
    check("rr_busy", busy, 0);
    check("rr_req_ready", req_ready, 0);
    check("rr_csb_addr", csb_addr, 0);
    check("rr_stray", stray, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rr_req_ready_after", req_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
